// File: rtl/seq_frame_tx_if.sv
// rtl/seq_frame_tx_if.sv - frame request and serial output bundle for seq_frame_tx
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              dout;
    logic              busy;
    logic              done;
    logic [2:0]        stat;

    modport master (output start, data, input dout, busy, done, stat);
    modport slave  (input start, data, output dout, busy, done, stat);
endinterface

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - Moore serial frame transmitter: sync word then payload, MSB first
module seq_frame_tx #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1101,
    parameter int                DATA_W = 8
) (
    input  logic           clk,
    input  logic           clr,
    seq_frame_tx_if.slave  bus
);
    localparam int FRAME_W = SYNC_W + DATA_W;
    localparam int MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SYNC = 3'b001,
        S_DATA = 3'b010,
        S_DONE = 3'b011
    } state_t;

    state_t             state, state_next;
    logic [FRAME_W-1:0] shreg, shreg_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_next = {SYNC, bus.data};
                    cnt_next   = '0;
                    state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                shreg_next = {shreg[FRAME_W-2:0], 1'b0};
                if (cnt == SYNC_LAST) begin
                    cnt_next   = '0;
                    state_next = S_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                shreg_next = {shreg[FRAME_W-2:0], 1'b0};
                if (cnt == DATA_LAST) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so clr clears them without waiting for an edge.
    always_comb begin
        bus.dout = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.stat = state;
        case (state)
            S_SYNC, S_DATA: begin
                bus.dout = shreg[FRAME_W-1];
                bus.busy = 1'b1;
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
